// File: rtl/axi_adc_capture.sv
// ADC capture stage: power-of-two sample averager feeding a FIFO, with an
// AXI4-Lite slave for control, status, FIFO drain and a result counter.
module axi_adc_capture #(
  parameter int ADC_WIDTH          = 14,
  parameter int FIFO_DEPTH_LOG2    = 4,
  parameter int C_S_AXI_DATA_WIDTH = 32,
  parameter int C_S_AXI_ADDR_WIDTH = 4
) (
  input  logic                            ACLK,
  input  logic                            ARESETN,
  input  logic [C_S_AXI_ADDR_WIDTH-1:0]   S_AXI_AWADDR,
  input  logic [2:0]                      S_AXI_AWPROT,
  input  logic                            S_AXI_AWVALID,
  output logic                            S_AXI_AWREADY,
  input  logic [C_S_AXI_DATA_WIDTH-1:0]   S_AXI_WDATA,
  input  logic [C_S_AXI_DATA_WIDTH/8-1:0] S_AXI_WSTRB,
  input  logic                            S_AXI_WVALID,
  output logic                            S_AXI_WREADY,
  output logic [1:0]                      S_AXI_BRESP,
  output logic                            S_AXI_BVALID,
  input  logic                            S_AXI_BREADY,
  input  logic [C_S_AXI_ADDR_WIDTH-1:0]   S_AXI_ARADDR,
  input  logic [2:0]                      S_AXI_ARPROT,
  input  logic                            S_AXI_ARVALID,
  output logic                            S_AXI_ARREADY,
  output logic [C_S_AXI_DATA_WIDTH-1:0]   S_AXI_RDATA,
  output logic [1:0]                      S_AXI_RRESP,
  output logic                            S_AXI_RVALID,
  input  logic                            S_AXI_RREADY,
  input  logic                            adc_valid,
  input  logic [ADC_WIDTH-1:0]            adc_data,
  output logic                            irq
);

  localparam int DEPTH = 1 << FIFO_DEPTH_LOG2;
  localparam int ACC_W = ADC_WIDTH + 7;
  localparam int LVL_W = FIFO_DEPTH_LOG2 + 1;
  localparam logic [LVL_W-1:0] DEPTH_L = LVL_W'(DEPTH);

  logic                          awready_q, bvalid_q, arready_q, rvalid_q, irq_q;
  logic [C_S_AXI_DATA_WIDTH-1:0] rdata_q, rdata_d;
  logic                          en_q, clr_q;
  logic [2:0]                    avg_q;
  logic [ACC_W-1:0]              acc_q;
  logic [7:0]                    cnt_q;
  logic [ADC_WIDTH-1:0]          res_q, res_d;
  logic                          push_q, ovf_q;
  logic [31:0]                   smp_cnt_q;
  logic [LVL_W-1:0]              wptr_q, rptr_q;
  logic [ADC_WIDTH-1:0]          mem_q [DEPTH];

  logic                 wr_hs_s, ar_hs_s, ctrl_wr_s, ctrl_chg_s;
  logic                 pop_s, push_ok_s, empty_s, full_s, avg_done_s;
  logic [LVL_W-1:0]     level_s;
  logic [ACC_W-1:0]     acc_sum_s, acc_shift_s;
  logic [7:0]           cnt_inc_s;
  logic [ADC_WIDTH-1:0] head_s;
  logic                 unused_s;

  assign S_AXI_AWREADY = awready_q;
  assign S_AXI_WREADY  = awready_q;
  assign S_AXI_BVALID  = bvalid_q;
  assign S_AXI_BRESP   = 2'b00;
  assign S_AXI_ARREADY = arready_q;
  assign S_AXI_RVALID  = rvalid_q;
  assign S_AXI_RDATA   = rdata_q;
  assign S_AXI_RRESP   = 2'b00;
  assign irq           = irq_q;

  assign unused_s = ^{S_AXI_AWPROT, S_AXI_ARPROT, S_AXI_AWADDR, S_AXI_ARADDR,
                      S_AXI_WDATA, S_AXI_WSTRB};

  assign wr_hs_s    = awready_q & S_AXI_AWVALID & S_AXI_WVALID;
  assign ar_hs_s    = arready_q & S_AXI_ARVALID;
  assign ctrl_wr_s  = wr_hs_s & (S_AXI_AWADDR[3:2] == 2'd0) & S_AXI_WSTRB[0];
  assign ctrl_chg_s = ctrl_wr_s & (S_AXI_WDATA[3:0] != {avg_q, en_q});

  assign level_s   = wptr_q - rptr_q;
  assign empty_s   = (level_s == {LVL_W{1'b0}});
  assign full_s    = (level_s == DEPTH_L);
  assign head_s    = mem_q[rptr_q[FIFO_DEPTH_LOG2-1:0]];
  assign pop_s     = ar_hs_s & (S_AXI_ARADDR[3:2] == 2'd2) & ~empty_s;
  // A full FIFO still takes a push when the same cycle pops the head.
  assign push_ok_s = push_q & ~clr_q & (~full_s | pop_s);

  assign acc_sum_s   = acc_q + ACC_W'(adc_data);
  assign cnt_inc_s   = cnt_q + 8'd1;
  assign avg_done_s  = (cnt_inc_s == (8'd1 << avg_q));
  assign acc_shift_s = acc_sum_s >> avg_q;
  assign res_d       = acc_shift_s[ADC_WIDTH-1:0];

  // Read data selection, sampled at the AR handshake.
  always_comb begin
    rdata_d = 32'd0;
    case (S_AXI_ARADDR[3:2])
      2'd0: rdata_d = {28'd0, avg_q, en_q};
      2'd1: rdata_d = {16'(level_s), 13'd0, ovf_q, full_s, empty_s};
      2'd2: begin
        if (empty_s) rdata_d = 32'd0;
        else         rdata_d = 32'(head_s);
      end
      2'd3: rdata_d = smp_cnt_q;
      default: rdata_d = 32'd0;
    endcase
  end

  // AXI handshake state and registered read data.
  always_ff @(posedge ACLK or negedge ARESETN) begin
    if (!ARESETN) begin
      awready_q <= 1'b0;
      bvalid_q  <= 1'b0;
      arready_q <= 1'b0;
      rvalid_q  <= 1'b0;
      rdata_q   <= 32'd0;
    end else begin
      awready_q <= S_AXI_AWVALID & S_AXI_WVALID & ~bvalid_q & ~awready_q;
      if (wr_hs_s)                    bvalid_q <= 1'b1;
      else if (bvalid_q & S_AXI_BREADY) bvalid_q <= 1'b0;
      arready_q <= S_AXI_ARVALID & ~rvalid_q & ~arready_q;
      if (ar_hs_s) begin
        rvalid_q <= 1'b1;
        rdata_q  <= rdata_d;
      end else if (rvalid_q & S_AXI_RREADY) begin
        rvalid_q <= 1'b0;
      end
    end
  end

  // Control register, deferred clear pulse and interrupt.
  always_ff @(posedge ACLK or negedge ARESETN) begin
    if (!ARESETN) begin
      en_q  <= 1'b0;
      avg_q <= 3'd0;
      clr_q <= 1'b0;
      irq_q <= 1'b0;
    end else begin
      clr_q <= ctrl_wr_s & S_AXI_WDATA[4];
      if (ctrl_wr_s) begin
        en_q  <= S_AXI_WDATA[0];
        avg_q <= S_AXI_WDATA[3:1];
      end
      irq_q <= en_q & ~empty_s;
    end
  end

  // Averager: accumulate 2^avg samples, then hand one result to the FIFO.
  always_ff @(posedge ACLK or negedge ARESETN) begin
    if (!ARESETN) begin
      acc_q  <= {ACC_W{1'b0}};
      cnt_q  <= 8'd0;
      res_q  <= {ADC_WIDTH{1'b0}};
      push_q <= 1'b0;
    end else if (clr_q | ctrl_chg_s | ~en_q) begin
      acc_q  <= {ACC_W{1'b0}};
      cnt_q  <= 8'd0;
      push_q <= 1'b0;
    end else if (adc_valid) begin
      if (avg_done_s) begin
        acc_q  <= {ACC_W{1'b0}};
        cnt_q  <= 8'd0;
        res_q  <= res_d;
        push_q <= 1'b1;
      end else begin
        acc_q  <= acc_sum_s;
        cnt_q  <= cnt_inc_s;
        push_q <= 1'b0;
      end
    end else begin
      push_q <= 1'b0;
    end
  end

  // FIFO pointers, sticky overflow and result counter.
  always_ff @(posedge ACLK or negedge ARESETN) begin
    if (!ARESETN) begin
      wptr_q    <= {LVL_W{1'b0}};
      rptr_q    <= {LVL_W{1'b0}};
      ovf_q     <= 1'b0;
      smp_cnt_q <= 32'd0;
    end else if (clr_q) begin
      wptr_q    <= {LVL_W{1'b0}};
      rptr_q    <= {LVL_W{1'b0}};
      ovf_q     <= 1'b0;
      smp_cnt_q <= 32'd0;
    end else begin
      if (push_ok_s) wptr_q <= wptr_q + {{(LVL_W-1){1'b0}}, 1'b1};
      if (pop_s)     rptr_q <= rptr_q + {{(LVL_W-1){1'b0}}, 1'b1};
      if (push_q & full_s & ~pop_s) ovf_q <= 1'b1;
      if (push_q) smp_cnt_q <= smp_cnt_q + 32'd1;
    end
  end

  // FIFO storage; contents need no reset since the pointers gate visibility.
  always_ff @(posedge ACLK) begin
    if (push_ok_s) mem_q[wptr_q[FIFO_DEPTH_LOG2-1:0]] <= res_q;
  end

endmodule

// File: tb/tb_axi_adc_capture.sv
// Directed bench for axi_adc_capture: register map, averaging, FIFO
// full/overflow, CLR, strobes, delayed AW, held RREADY and async reset.
module tb_axi_adc_capture;

  logic        ACLK = 1'b0;
  logic        ARESETN;
  logic [3:0]  S_AXI_AWADDR, S_AXI_ARADDR;
  logic [2:0]  S_AXI_AWPROT, S_AXI_ARPROT;
  logic        S_AXI_AWVALID, S_AXI_AWREADY;
  logic [31:0] S_AXI_WDATA;
  logic [3:0]  S_AXI_WSTRB;
  logic        S_AXI_WVALID, S_AXI_WREADY;
  logic [1:0]  S_AXI_BRESP, S_AXI_RRESP;
  logic        S_AXI_BVALID, S_AXI_BREADY;
  logic        S_AXI_ARVALID, S_AXI_ARREADY;
  logic [31:0] S_AXI_RDATA;
  logic        S_AXI_RVALID, S_AXI_RREADY;
  logic        adc_valid;
  logic [13:0] adc_data;
  logic        irq;

  int total = 0;
  int bad   = 0;
  logic [31:0] rd;

  always #5 ACLK = ~ACLK;

  axi_adc_capture dut (
    .ACLK(ACLK), .ARESETN(ARESETN),
    .S_AXI_AWADDR(S_AXI_AWADDR), .S_AXI_AWPROT(S_AXI_AWPROT),
    .S_AXI_AWVALID(S_AXI_AWVALID), .S_AXI_AWREADY(S_AXI_AWREADY),
    .S_AXI_WDATA(S_AXI_WDATA), .S_AXI_WSTRB(S_AXI_WSTRB),
    .S_AXI_WVALID(S_AXI_WVALID), .S_AXI_WREADY(S_AXI_WREADY),
    .S_AXI_BRESP(S_AXI_BRESP), .S_AXI_BVALID(S_AXI_BVALID),
    .S_AXI_BREADY(S_AXI_BREADY),
    .S_AXI_ARADDR(S_AXI_ARADDR), .S_AXI_ARPROT(S_AXI_ARPROT),
    .S_AXI_ARVALID(S_AXI_ARVALID), .S_AXI_ARREADY(S_AXI_ARREADY),
    .S_AXI_RDATA(S_AXI_RDATA), .S_AXI_RRESP(S_AXI_RRESP),
    .S_AXI_RVALID(S_AXI_RVALID), .S_AXI_RREADY(S_AXI_RREADY),
    .adc_valid(adc_valid), .adc_data(adc_data), .irq(irq)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
    end
  endtask

  task automatic axi_write(input logic [3:0] a, input logic [31:0] d,
                           input logic [3:0] s, input int aw_delay);
    bit ok;
    @(negedge ACLK);
    S_AXI_AWADDR = a; S_AXI_WDATA = d; S_AXI_WSTRB = s; S_AXI_WVALID = 1'b1;
    for (int i = 0; i < aw_delay; i++) begin
      @(negedge ACLK);
      check("w_without_aw_wready", {31'd0, S_AXI_WREADY}, 32'd0);
    end
    S_AXI_AWVALID = 1'b1;
    ok = 1'b0;
    for (int i = 0; i < 50; i++) begin
      @(negedge ACLK);
      if (S_AXI_AWREADY && S_AXI_WREADY) begin ok = 1'b1; break; end
    end
    check("aw_handshake", {31'd0, ok}, 32'd1);
    @(posedge ACLK); #1;
    S_AXI_AWVALID = 1'b0; S_AXI_WVALID = 1'b0; S_AXI_BREADY = 1'b1;
    ok = 1'b0;
    for (int i = 0; i < 50; i++) begin
      if (S_AXI_BVALID) begin ok = 1'b1; break; end
      @(negedge ACLK);
    end
    check("bvalid", {31'd0, ok}, 32'd1);
    check("bresp", {30'd0, S_AXI_BRESP}, 32'd0);
    @(posedge ACLK); #1;
    S_AXI_BREADY = 1'b0;
  endtask

  task automatic axi_read(input logic [3:0] a, input int hold, output logic [31:0] d);
    bit ok;
    d = 32'hDEAD_BEEF;
    @(negedge ACLK);
    S_AXI_ARADDR = a; S_AXI_ARVALID = 1'b1; S_AXI_RREADY = 1'b0;
    ok = 1'b0;
    for (int i = 0; i < 50; i++) begin
      @(negedge ACLK);
      if (S_AXI_ARREADY) begin ok = 1'b1; break; end
    end
    if (!ok) begin
      check("ar_handshake", 32'd0, 32'd1);
      S_AXI_ARVALID = 1'b0;
      return;
    end
    @(posedge ACLK); #1;
    S_AXI_ARVALID = 1'b0;
    ok = 1'b0;
    for (int i = 0; i < 50; i++) begin
      if (S_AXI_RVALID) begin ok = 1'b1; break; end
      @(negedge ACLK);
    end
    if (!ok) begin
      check("rvalid", 32'd0, 32'd1);
      return;
    end
    d = S_AXI_RDATA;
    check("rresp", {30'd0, S_AXI_RRESP}, 32'd0);
    for (int i = 0; i < hold; i++) begin
      @(negedge ACLK);
      check("rdata_stable", S_AXI_RDATA, d);
      check("rvalid_held", {31'd0, S_AXI_RVALID}, 32'd1);
    end
    S_AXI_RREADY = 1'b1;
    @(posedge ACLK); #1;
    S_AXI_RREADY = 1'b0;
  endtask

  task automatic sample(input logic [13:0] v);
    @(negedge ACLK);
    adc_valid = 1'b1; adc_data = v;
    @(negedge ACLK);
    adc_valid = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge ACLK);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    ARESETN = 1'b0;
    S_AXI_AWADDR = 4'h0; S_AXI_ARADDR = 4'h0;
    S_AXI_AWPROT = 3'd0; S_AXI_ARPROT = 3'd0;
    S_AXI_AWVALID = 1'b0; S_AXI_WVALID = 1'b0; S_AXI_BREADY = 1'b0;
    S_AXI_WDATA = 32'd0; S_AXI_WSTRB = 4'h0;
    S_AXI_ARVALID = 1'b0; S_AXI_RREADY = 1'b0;
    adc_valid = 1'b0; adc_data = 14'd0;
    #22;
    check("rst_ready_valid", {28'd0, S_AXI_AWREADY, S_AXI_BVALID, S_AXI_ARREADY, S_AXI_RVALID}, 32'd0);
    check("rst_rdata", S_AXI_RDATA, 32'd0);
    check("rst_irq", {31'd0, irq}, 32'd0);
    @(negedge ACLK);
    ARESETN = 1'b1;

    axi_read(4'h0, 0, rd); check("rst_ctrl", rd, 32'h0);
    axi_read(4'h4, 0, rd); check("rst_status", rd, 32'h0000_0001);
    axi_read(4'h8, 0, rd); check("rst_data", rd, 32'h0);
    axi_read(4'hC, 0, rd); check("rst_scnt", rd, 32'h0);

    // Pass-through mode.
    axi_write(4'h0, 32'h1, 4'hF, 0);
    for (int i = 1; i <= 4; i++) sample(14'(i));
    idle(4);
    for (int i = 1; i <= 4; i++) begin
      axi_read(4'h8, 0, rd); check("pass_data", rd, 32'(i));
    end
    axi_read(4'h4, 0, rd); check("pass_status", rd, 32'h0000_0001);
    axi_read(4'hC, 0, rd); check("pass_scnt", rd, 32'd4);

    // Average of four, with CLR so the result count restarts.
    axi_write(4'h0, 32'h15, 4'hF, 0);
    axi_read(4'h0, 0, rd); check("avg_ctrl", rd, 32'h5);
    sample(14'd10); sample(14'd20); sample(14'd30); sample(14'd41);
    idle(3);
    check("avg_irq_high", {31'd0, irq}, 32'd1);
    axi_read(4'h4, 0, rd); check("avg_status", rd, 32'h0001_0000);
    axi_read(4'h8, 0, rd); check("avg_data", rd, 32'd25);
    idle(2);
    check("avg_irq_low", {31'd0, irq}, 32'd0);
    axi_read(4'hC, 0, rd); check("avg_scnt", rd, 32'd1);

    // Fill past capacity.
    axi_write(4'h0, 32'h1, 4'hF, 0);
    for (int i = 1; i <= 17; i++) sample(14'(i));
    idle(3);
    axi_read(4'h4, 0, rd); check("full_status", rd, 32'h0010_0006);
    for (int i = 1; i <= 16; i++) begin
      axi_read(4'h8, 0, rd); check("full_data", rd, 32'(i));
    end
    axi_read(4'h4, 0, rd); check("drained_status", rd, 32'h0000_0005);
    axi_read(4'hC, 0, rd); check("full_scnt", rd, 32'd18);

    // CLR with data queued and overflow set.
    for (int i = 1; i <= 5; i++) sample(14'(i));
    idle(3);
    axi_read(4'h4, 0, rd); check("pre_clr_status", rd, 32'h0005_0004);
    axi_write(4'h0, 32'h11, 4'hF, 0);
    axi_read(4'h4, 0, rd); check("clr_status", rd, 32'h0000_0001);
    axi_read(4'hC, 0, rd); check("clr_scnt", rd, 32'd0);
    axi_read(4'h0, 0, rd); check("clr_ctrl", rd, 32'h1);

    // Strobes, delayed AW, read-only write, held RREADY.
    axi_write(4'h0, 32'hFF, 4'h0, 0);
    axi_read(4'h0, 0, rd); check("strb0_ctrl", rd, 32'h1);
    axi_write(4'h0, 32'h3, 4'hF, 3);
    axi_read(4'h0, 0, rd); check("late_aw_ctrl", rd, 32'h3);
    sample(14'd6); sample(14'd8); sample(14'd2); sample(14'd4);
    idle(3);
    axi_read(4'h8, 5, rd); check("hold_data", rd, 32'd7);
    axi_read(4'h4, 0, rd); check("hold_status", rd, 32'h0001_0000);
    axi_write(4'hC, 32'hFFFF_FFFF, 4'hF, 0);
    axi_read(4'hC, 0, rd); check("ro_write_scnt", rd, 32'd2);
    axi_read(4'h8, 0, rd); check("avg2_data", rd, 32'd3);
    axi_read(4'h8, 0, rd); check("empty_data", rd, 32'd0);
    axi_read(4'h4, 0, rd); check("empty_status", rd, 32'h0000_0001);

    // Disabled: samples are ignored.
    axi_write(4'h0, 32'h0, 4'hF, 0);
    sample(14'd5); sample(14'd5);
    idle(3);
    axi_read(4'h4, 0, rd); check("dis_status", rd, 32'h0000_0001);
    axi_read(4'hC, 0, rd); check("dis_scnt", rd, 32'd2);

    // Asynchronous reset in the middle of a read.
    axi_write(4'h0, 32'h1, 4'hF, 0);
    sample(14'd9);
    idle(3);
    @(negedge ACLK);
    S_AXI_ARADDR = 4'h8; S_AXI_ARVALID = 1'b1;
    @(posedge ACLK); #2;
    ARESETN = 1'b0;
    #1;
    check("midrst_ready_valid", {28'd0, S_AXI_AWREADY, S_AXI_BVALID, S_AXI_ARREADY, S_AXI_RVALID}, 32'd0);
    check("midrst_irq", {31'd0, irq}, 32'd0);
    S_AXI_ARVALID = 1'b0;
    @(negedge ACLK);
    ARESETN = 1'b1;
    axi_read(4'h4, 0, rd); check("postrst_status", rd, 32'h0000_0001);
    axi_read(4'h0, 0, rd); check("postrst_ctrl", rd, 32'h0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
